lcd_timing_driver: RTL and testbench

Display-side counterpart of the pixel compositor: generates the LCD raster scan (horizontal/vertical counters, sync and data-enable strobes), issues the pixel coordinate request (`lcd_xpos`, `lcd_ypos`) to the compositor, samples the returned 24-bit pixel word and drives the panel RGB565 pins. It also produces the once-per-frame tick that paces game movement.

---
 rtl/lcd_timing_driver.sv | 84 ++++++++
 tb/tb_lcd_timing_driver.sv | 132 +++++++++++++
 2 files changed

// File: rtl/lcd_timing_driver.sv
// lcd_timing_driver: LCD raster scan, pixel coordinate request and registered RGB565/sync/DE output.
module lcd_timing_driver #(
    parameter int H_SYNC  = 1,
    parameter int H_BACK  = 46,
    parameter int H_DISP  = 800,
    parameter int H_FRONT = 210,
    parameter int V_SYNC  = 1,
    parameter int V_BACK  = 23,
    parameter int V_DISP  = 480,
    parameter int V_FRONT = 22
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lcd_en,
    input  logic [23:0] lcd_data,
    output logic [11:0] lcd_xpos,
    output logic [11:0] lcd_ypos,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic        lcd_de,
    output logic [4:0]  lcd_r,
    output logic [5:0]  lcd_g,
    output logic [4:0]  lcd_b,
    output logic        frame_tick
);
    localparam logic [11:0] H_TOT = 12'(H_SYNC + H_BACK + H_DISP + H_FRONT);
    localparam logic [11:0] V_TOT = 12'(V_SYNC + V_BACK + V_DISP + V_FRONT);
    localparam logic [11:0] H_SY  = 12'(H_SYNC);
    localparam logic [11:0] V_SY  = 12'(V_SYNC);
    localparam logic [11:0] H_ST  = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] V_ST  = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] H_END = 12'(H_SYNC + H_BACK + H_DISP);
    localparam logic [11:0] V_END = 12'(V_SYNC + V_BACK + V_DISP);

    logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, tick_q, tick_d;
    logic [15:0] rgb_q, rgb_d;
    logic        h_last, v_last, active;
    logic        unused_pad;

    assign unused_pad = ^{lcd_data[23:21], lcd_data[15:14], lcd_data[7:5]};

    always_comb begin
        h_last   = h_cnt_q == H_TOT - 12'd1;
        v_last   = v_cnt_q == V_TOT - 12'd1;
        h_cnt_d  = (!lcd_en || h_last) ? '0 : h_cnt_q + 12'd1;
        v_cnt_d  = !lcd_en ? '0 : h_last ? (v_last ? '0 : v_cnt_q + 12'd1) : v_cnt_q;
        // Gated by lcd_en so a disabled cycle never requests or samples a pixel.
        active   = lcd_en && h_cnt_q >= H_ST && h_cnt_q < H_END && v_cnt_q >= V_ST && v_cnt_q < V_END;
        lcd_xpos = active ? h_cnt_q - H_ST : '0;
        lcd_ypos = active ? v_cnt_q - V_ST : '0;
        hs_d     = !lcd_en || h_cnt_q >= H_SY;
        vs_d     = !lcd_en || v_cnt_q >= V_SY;
        de_d     = active;
        rgb_d    = active ? {lcd_data[20:16], lcd_data[13:8], lcd_data[4:0]} : '0;
        tick_d   = lcd_en && h_cnt_q == '0 && v_cnt_q == V_END;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            de_q    <= 1'b0;
            rgb_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            rgb_q   <= rgb_d;
            tick_q  <= tick_d;
        end
    end

    assign lcd_hsync  = hs_q;
    assign lcd_vsync  = vs_q;
    assign lcd_de     = de_q;
    assign {lcd_r, lcd_g, lcd_b} = rgb_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_lcd_timing_driver.sv
// tb_lcd_timing_driver: directed + randomized checks of the LCD scan against a frame-position model.
module tb_lcd_timing_driver;
    localparam int HS = 2, HB = 3, HD = 8, HF = 3;
    localparam int VS = 1, VB = 2, VD = 4, VF = 1;
    localparam int HT = HS + HB + HD + HF;
    localparam int VT = VS + VB + VD + VF;
    localparam int FR = HT * VT;

    logic        clk = 1'b0, rst_n = 1'b0, lcd_en = 1'b0;
    logic [23:0] lcd_data = '0;
    logic [11:0] lcd_xpos, lcd_ypos;
    logic        lcd_hsync, lcd_vsync, lcd_de, frame_tick;
    logic [4:0]  lcd_r, lcd_b;
    logic [5:0]  lcd_g;

    lcd_timing_driver #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .lcd_en(lcd_en), .lcd_data(lcd_data),
        .lcd_xpos(lcd_xpos), .lcd_ypos(lcd_ypos),
        .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
        .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int compared = 0, mism = 0;
    int pos = 0, cyc = 0, first_de = -1, de_cnt = 0;
    int ticks[$];
    logic        e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_tk = 1'b0;
    logic [15:0] e_rgb = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_exp();
        e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_tk = 1'b0; e_rgb = '0; pos = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hsync"}, 32'(lcd_hsync), 1);
        chk({tag, "_vsync"}, 32'(lcd_vsync), 1);
        chk({tag, "_de"}, 32'(lcd_de), 0);
        chk({tag, "_rgb"}, 32'({lcd_r, lcd_g, lcd_b}), 0);
        chk({tag, "_tick"}, 32'(frame_tick), 0);
        chk({tag, "_xpos"}, 32'(lcd_xpos), 0);
        chk({tag, "_ypos"}, 32'(lcd_ypos), 0);
    endtask

    // One clock: present inputs for position pos, check outputs, predict the next edge.
    task automatic step(input logic en);
        int h, v, x, y;
        logic act;
        @(negedge clk);
        lcd_en = en;
        h = pos % HT;
        v = pos / HT;
        act = en && h >= HS + HB && h < HS + HB + HD && v >= VS + VB && v < VS + VB + VD;
        x = act ? h - (HS + HB) : 0;
        y = act ? v - (VS + VB) : 0;
        lcd_data = act ? {3'($urandom), 5'(x), 2'($urandom), 6'(y), 3'($urandom), 5'h1F}
                       : ($urandom_range(1) == 1 ? 24'hFFFFFF : 24'($urandom));
        #1;
        chk("xpos", 32'(lcd_xpos), 32'(x));
        chk("ypos", 32'(lcd_ypos), 32'(y));
        chk("hsync", 32'(lcd_hsync), 32'(e_hs));
        chk("vsync", 32'(lcd_vsync), 32'(e_vs));
        chk("de", 32'(lcd_de), 32'(e_de));
        chk("rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'(e_rgb));
        chk("tick", 32'(frame_tick), 32'(e_tk));
        if (lcd_de) de_cnt++;
        if (lcd_de && first_de < 0) first_de = cyc;
        if (frame_tick) ticks.push_back(cyc);
        if (en) begin
            e_hs  = h >= HS;
            e_vs  = v >= VS;
            e_de  = act;
            e_rgb = act ? {5'(x), 6'(y), 5'h1F} : '0;
            e_tk  = h == 0 && v == VS + VB + VD;
            pos   = (pos + 1) % FR;
        end else reset_exp();
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        lcd_en = 1'b0;
        #1;
        chk_reset("async_rst");
        reset_exp();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0; first_de = -1; de_cnt = 0;
        repeat (400) step(1'b1);
        chk("first_de", 32'(first_de), 54);
        chk("de_total", 32'(de_cnt), 96);
        chk("tick_count", 32'(ticks.size()), 3);
        if (ticks.size() == 3) begin
            chk("tick0", 32'(ticks[0]), 113);
            chk("tick1", 32'(ticks[1]), 241);
            chk("tick2", 32'(ticks[2]), 369);
        end
        do_reset();
        cyc = 0;
        repeat (60) step(1'b1);
        do_reset();
        cyc = 0; first_de = -1;
        repeat (70) step(1'b1);
        chk("first_de_after_rst", 32'(first_de), 54);
        repeat (10) step(1'b0);
        repeat (20) step(1'b1);
        repeat (600) step($urandom_range(9) != 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
